// File: rtl/arm_if_pkg.sv
// Shared types and constants for the ARM instruction-fetch stage.
package arm_if_pkg;

  typedef enum logic [1:0] {ISSUE, WAIT, DROP} fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// DEPTH-entry prefetch queue of {pc, instr}; flush beats push, head is read combinationally.
module if_prefetch_fifo
  import arm_if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns fetch PC, one outstanding imem request, prefetch queue toward IF/ID.
// Define IF_BYPASS_EN to present a response in its arrival cycle when the queue is empty.
module if_fetch_unit
  import arm_if_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, pc_inc;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_entry;
  logic          accept, bypass, empty, push, pop;

  assign pc_inc     = fetch_pc + WORD_BYTES;
  assign empty      = (count == '0);
  assign accept     = (state == WAIT) && imem_rvalid && !branchTaken;
`ifdef IF_BYPASS_EN
  assign bypass     = accept && empty;
`else
  assign bypass     = 1'b0;
`endif
  // A bypassed word consumed downstream this cycle never enters the queue.
  assign push       = accept && !(bypass && !freeze);
  assign pop        = !empty && !freeze && !branchTaken;
  assign push_entry = '{pc: pc_inc, instr: imem_rdata};

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (branchTaken),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ISSUE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Request is gated by rst so nothing is issued while reset is held.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    imem_req     = 1'b0;
    case (state)
      ISSUE: begin
        if (rst && (count < FULL) && !branchTaken) begin
          imem_req  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = ISSUE;
          if (!branchTaken) fetch_pc_nxt = pc_inc;
        end else if (branchTaken) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
    if (branchTaken) fetch_pc_nxt = branchAddr;
  end

  assign imem_addr = imem_req ? fetch_pc : '0;

  always_comb begin
    valid       = 1'b0;
    pc          = '0;
    instruction = NOP_INSTR;
    if (!empty) begin
      valid       = 1'b1;
      pc          = head.pc;
      instruction = head.instr;
    end else if (bypass) begin
      valid       = 1'b1;
      pc          = pc_inc;
      instruction = imem_rdata;
    end
  end

endmodule
